// File: rtl/riscv_pkg.sv
// Shared core definitions used by the fetch front end: word width, fetch FSM
// states and the canonical NOP encoding that downstream stages use on flush.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch front-end bus: instruction-memory req/gnt/rvalid channel, redirect
// from EX and the valid/ready instruction stream toward decode.
interface fetch_prefetch_buffer_if #(parameter int WIDTH = 32);
  logic             req;
  logic [WIDTH-1:0] addr;
  logic             gnt;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             inst_ready;
  logic             inst_valid;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_4;

  modport master (
    output req, addr, inst_valid, inst, pc, pc_plus_4,
    input  gnt, rvalid, rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  req, addr, inst_valid, inst, pc, pc_plus_4,
    output gnt, rvalid, rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// In-order DEPTH x DW FIFO holding {instruction, pc} pairs; push and pop may
// coincide even when full, clear empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          clear,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues imem requests and
// buffers in-order responses for decode. Optional PREFETCH_BYPASS_EN forwards
// a response straight to decode when the buffer is empty.
module fetch_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = XLEN,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst_i,
  fetch_prefetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t       state;
  logic [WIDTH-1:0]   fetch_pc, resp_pc, target;
  logic [CW-1:0]      outstanding, out_next, count;
  logic               full, empty;
  logic               grant, ret, push, pop, byp, byp_take;
  logic [2*WIDTH-1:0] head;

  // Request only while there is room for every buffered plus in-flight word;
  // gated by reset so the bus is idle while reset is held.
  assign bus.req  = rst_i && (state == FETCH) && !full &&
                    (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign bus.addr = fetch_pc;
  assign grant    = bus.req && bus.gnt;
  assign ret      = bus.rvalid && (outstanding != '0);
  assign out_next = outstanding + CW'(grant) - CW'(ret);
  assign target   = {bus.redirect_pc[WIDTH-1:2], 2'b00};

`ifdef PREFETCH_BYPASS_EN
  assign byp = empty && (state == FETCH) && !bus.redirect && bus.rvalid;
`else
  assign byp = 1'b0;
`endif
  assign byp_take = byp && bus.inst_ready;

  assign push = (state == FETCH) && bus.rvalid && !bus.redirect && !byp_take;
  assign pop  = !empty && bus.inst_ready;

  assign bus.inst_valid        = !empty || byp;
  assign {bus.inst, bus.pc}    = byp ? {bus.rdata, resp_pc} : head;
  assign bus.pc_plus_4         = bus.pc + WIDTH'(4);

  fetch_fifo #(.DEPTH(DEPTH), .DW(2*WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_i),
    .push  (push),
    .din   ({bus.rdata, resp_pc}),
    .pop   (pop),
    .clear (bus.redirect),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A grant coinciding with redirect still counts as in flight and must drain
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      if (bus.redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        state    <= (out_next != '0) ? DRAIN : FETCH;
      end else begin
        if (grant) fetch_pc <= fetch_pc + WIDTH'(4);
        if (state == FETCH && bus.rvalid) resp_pc <= resp_pc + WIDTH'(4);
        if (state == DRAIN && out_next == '0) state <= FETCH;
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: in-order memory model, queue-level
// reference of the fetch/buffer rules, directed scenarios plus random traffic.
module tb_fetch_prefetch_buffer;
  localparam int          W   = 32;
  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_buffer_if #(.WIDTH(W)) bus();
  fetch_prefetch_buffer #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_i(rst_i), .bus(bus)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] cyc; } pend_t;
  typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;

  pend_t       pend[$];
  ent_t        mfifo[$];
  logic [31:0] m_fpc, m_rpc;
  int          m_out;
  bit          m_drain;
  int          cyc, n_cmp, n_bad, first_valid, grants;
  logic [31:0] log_pc[$], log_inst[$], log_pc4[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'd13;
      32'h4:   return 32'd93;
      32'h8:   return 32'd113;
      32'hC:   return 32'h193;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs are applied at posedge+1, outputs compared at posedge+2.
  task automatic tick(input bit g, input bit rv_en, input bit rdy, input bit rd,
                      input logic [31:0] tgt);
    bit          rv, exp_req, byp, exp_valid, grant, take;
    logic [31:0] rword;
    ent_t        head;
    int          out_n;
    rv    = rv_en && pend.size() > 0 && pend[0].cyc < 32'(cyc);
    rword = rv ? mem_word(pend[0].addr) : $urandom;
    bus.gnt = g; bus.rvalid = rv; bus.rdata = rword;
    bus.redirect = rd; bus.redirect_pc = tgt; bus.inst_ready = rdy;
    #1;
    exp_req = !m_drain && (mfifo.size() + m_out < D);
    byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp = mfifo.size() == 0 && !m_drain && !rd && rv;
`endif
    exp_valid = mfifo.size() > 0 || byp;
    head = '0;
    if (byp) head = '{inst: rword, pc: m_rpc};
    else if (mfifo.size() > 0) head = mfifo[0];
    chk("req", 32'(bus.req), 32'(exp_req));
    chk("addr", bus.addr, m_fpc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("inst", bus.inst, head.inst);
      chk("pc", bus.pc, head.pc);
      chk("pc_plus_4", bus.pc_plus_4, head.pc + 32'd4);
    end
    if (bus.inst_valid && first_valid < 0) first_valid = cyc;
    if (bus.inst_valid && rdy) begin
      log_pc.push_back(bus.pc); log_inst.push_back(bus.inst); log_pc4.push_back(bus.pc_plus_4);
    end
    grant = exp_req && g;
    take  = exp_valid && rdy;
    if (rv) pend.delete(0);
    if (grant) begin pend.push_back('{addr: m_fpc, cyc: 32'(cyc)}); grants++; end
    out_n = m_out + int'(grant) - int'(rv);
    if (rd) begin
      mfifo.delete();
      m_fpc = {tgt[31:2], 2'b00};
      m_rpc = m_fpc;
      m_drain = out_n > 0;
    end else begin
      if (grant) m_fpc += 32'd4;
      if (m_drain) begin
        if (out_n == 0) m_drain = 1'b0;
      end else begin
        if (take && !byp) mfifo.delete(0);
        if (rv) begin
          if (!(byp && rdy)) mfifo.push_back('{inst: rword, pc: m_rpc});
          m_rpc += 32'd4;
        end
      end
    end
    m_out = out_n;
    cyc++;
    @(posedge clk); #1;
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases mid-cycle.
  task automatic do_reset();
    rst_i = 1'b0;
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0; bus.redirect = 0;
    bus.redirect_pc = 0; bus.inst_ready = 0;
    #1;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_addr", bus.addr, RPC);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_pc4", bus.pc_plus_4, 32'd4);
    mfifo.delete(); pend.delete();
    m_fpc = RPC; m_rpc = RPC; m_out = 0; m_drain = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    cyc = 0; first_valid = -1; grants = 0;
    log_pc.delete(); log_inst.delete(); log_pc4.delete();
  endtask

  initial begin
    int g0;
    n_cmp = 0; n_bad = 0;
    @(posedge clk); #1;

    // Streaming from reset: pc 0,4,8 with the memory words in order
    do_reset();
    repeat (8) tick(1, 1, 1, 0, 0);
`ifdef PREFETCH_BYPASS_EN
    chk("p1_latency", 32'(first_valid), 32'd1);
`else
    chk("p1_latency", 32'(first_valid), 32'd2);
`endif
    if (log_pc.size() < 3) chk("p1_count", 32'(log_pc.size()), 32'd3);
    else begin
      chk("p1_pc0", log_pc[0], 32'h0); chk("p1_inst0", log_inst[0], 32'd13);
      chk("p1_pc1", log_pc[1], 32'h4); chk("p1_inst1", log_inst[1], 32'd93);
      chk("p1_pc2", log_pc[2], 32'h8); chk("p1_inst2", log_inst[2], 32'd113);
    end

    // Stalled decode: exactly DEPTH grants, then resume only after a pop
    do_reset();
    repeat (10) tick(1, 1, 0, 0, 0);
    chk("p2_grants", 32'(grants), 32'd4);
    chk("p2_req_off", 32'(bus.req), 32'd0);
    g0 = grants;
    tick(1, 1, 1, 0, 0);
    chk("p2_no_grant_on_pop", 32'(grants - g0), 32'd0);
    tick(1, 1, 1, 0, 0);
    chk("p2_grant_after_pop", 32'(grants - g0), 32'd1);
    repeat (4) tick(1, 1, 1, 0, 0);
    if (log_pc.size() < 4) chk("p2_count", 32'(log_pc.size()), 32'd4);
    else for (int i = 0; i < 4; i++) chk("p2_pc_order", log_pc[i], 32'(4 * i));

    // No grant: address held, nothing delivered
    do_reset();
    repeat (5) begin
      tick(0, 1, 1, 0, 0);
      chk("p3_addr", bus.addr, RPC);
      chk("p3_valid", 32'(bus.inst_valid), 32'd0);
    end

    // Redirect with two in flight: drain, then deliver from the target
    do_reset();
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 32'h103);
    chk("p4_drain_req", 32'(bus.req), 32'd0);
    repeat (8) tick(1, 1, 1, 0, 0);
    if (log_pc.size() < 1) chk("p4_count", 32'(log_pc.size()), 32'd1);
    else begin
      chk("p4_pc", log_pc[0], 32'h100);
      chk("p4_pc4", log_pc4[0], 32'h104);
      chk("p4_inst", log_inst[0], mem_word(32'h100));
    end

    // Redirect + rvalid + pop in one cycle
    do_reset();
    repeat (3) tick(1, 1, 0, 0, 0);
    tick(0, 1, 1, 1, 32'h200);
    chk("p5_valid", 32'(bus.inst_valid), 32'd0);
    chk("p5_addr", bus.addr, 32'h200);
    chk("p5_req", 32'(bus.req), 32'd1);
    chk("p5_pops", 32'(log_pc.size()), 32'd1);
    if (log_pc.size() > 0) chk("p5_pc", log_pc[0], 32'h0);

    // Random traffic against the model
    do_reset();
    repeat (3000)
      tick(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
           ($urandom % 20) == 0, {20'h0, 12'($urandom)});

    // Reset mid-stream with three buffered words
    do_reset();
    for (int k = 0; k < 20 && mfifo.size() != 3; k++) tick(1, 1, 0, 0, 0);
    chk("p7_fill", 32'(mfifo.size()), 32'd3);
    chk("p7_valid_before", 32'(bus.inst_valid), 32'd1);
    do_reset();
    repeat (6) tick(1, 1, 1, 0, 0);
    if (log_pc.size() < 1) chk("p7_count", 32'(log_pc.size()), 32'd1);
    else chk("p7_restart_pc", log_pc[0], RPC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
